pulse_period_meter: RTL

Measures the distance, in `clk` cycles, between consecutive rising edges of a slow pulse input. Typical sources are a divided tick, a board signal or an external event line. It is the inverse of the team's tick divider: the divider turns a cycle count into a pulse, and this block turns a pulse back into a cycle count. It sits on the board side next to the divider and feeds display and self-check logic with a measured period plus a one-cycle valid strobe.

---
 rtl/board_pkg.sv | 14 +
 rtl/sync_rise_detect.sv | 35 +++
 rtl/pulse_period_meter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared board-side definitions for the pulse period meter and its helpers.
//   meter_state_t : measurement FSM states (IDLE waits for an arming edge,
//                   MEASURE counts cycles between edges)
//   SYNC_DEPTH    : number of flops in the input synchronizer chain
package board_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous level into the clk domain and flags its
// rising edges. This block is also usable for board buttons.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset; clears every flop to 0
//   din   : asynchronous input level
//   rise  : high for one cycle when the synchronized level goes 0 -> 1
module sync_rise_detect
    import board_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    // sync_r[0] is the first (metastability-catching) stage, the MSB is the
    // last synchronizer stage; dly_r holds the previous synchronized sample.
    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  dly_r;

    // Synchronizer chain plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_DEPTH{1'b0}};
            dly_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], din};
            dly_r  <= sync_r[SYNC_DEPTH-1];
        end
    end

    assign rise = sync_r[SYNC_DEPTH-1] & ~dly_r;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the number of clk cycles between consecutive rising edges of a
// slow pulse input and reports it with a one-cycle valid strobe.
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   en           : measurement enable; low forces IDLE
//   pulse_in     : asynchronous pulse being measured
//   period       : last valid measured period in cycles (held between updates)
//   period_valid : one-cycle strobe, period updated this cycle
//   timeout      : one-cycle strobe, counter saturated with no edge
//   overflow     : sticky, set with timeout, cleared by next period_valid
//   busy         : high while measuring
module pulse_period_meter
    import board_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             rise_s;

    meter_state_t     state_r;
    meter_state_t     state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_s;
    logic             valid_r;
    logic             valid_s;
    logic             timeout_r;
    logic             timeout_s;
    logic             overflow_r;
    logic             overflow_s;
    logic             busy_r;

    sync_rise_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pulse_in),
        .rise  (rise_s)
    );

    // Next-state, counter and output-register decode for the measurement FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        period_s   = period_r;
        valid_s    = 1'b0;
        timeout_s  = 1'b0;
        overflow_s = overflow_r;

        if (!en) begin
            // Counter is left as-is; it is reloaded on the next arming edge.
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    // First edge only arms; there is no start reference yet.
                    if (rise_s) begin
                        state_s = MEASURE;
                        cnt_s   = CNT_ONE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                MEASURE: begin
                    // An edge on the saturation cycle is still a valid period.
                    if (rise_s) begin
                        period_s   = cnt_r;
                        valid_s    = 1'b1;
                        overflow_s = 1'b0;
                        cnt_s      = CNT_ONE;
                    end else if (cnt_r == CNT_MAX) begin
                        timeout_s  = 1'b1;
                        overflow_s = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            period_r   <= CNT_ZERO;
            valid_r    <= 1'b0;
            timeout_r  <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            period_r   <= period_s;
            valid_r    <= valid_s;
            timeout_r  <= timeout_s;
            overflow_r <= overflow_s;
            busy_r     <= (state_s == MEASURE);
        end
    end

    assign period       = period_r;
    assign period_valid = valid_r;
    assign timeout      = timeout_r;
    assign overflow     = overflow_r;
    assign busy         = busy_r;

endmodule
